// File: rtl/gradient_update.sv
// rtl/gradient_update.sv - per-element weight update w -= lr * dcost * dto_all * dstart
//
// Purpose: captures one bundle of partial derivatives and weights, then walks the
// elements one by one through a single shared fixed-point multiplier (three
// multiplies) and a saturating subtract, and presents the updated weight vector.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  input bundle handshake (ready only in IDLE)
//   weight          current weights, element i at [i*data_size +: data_size]
//   diff_cost       d(cost)/d(prediction), same packing
//   diff_to_all     d(prediction)/d(z), same packing
//   diff_start      d(z)/d(weight), same packing
//   learning_rate   scalar, same fixed-point format
//   out_valid/ready result handshake
//   weight_out      updated weights, same packing as weight
module gradient_update #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int frac_bits = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [size*data_size-1:0] weight,
    input  logic [size*data_size-1:0] diff_cost,
    input  logic [size*data_size-1:0] diff_to_all,
    input  logic [size*data_size-1:0] diff_start,
    input  logic [data_size-1:0]      learning_rate,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [size*data_size-1:0] weight_out
);

    localparam int VW = size * data_size;
    localparam int PW = 2 * data_size;
    localparam int IW = (size > 1) ? $clog2(size) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL_A = 3'd1;
    localparam logic [2:0] S_MUL_B = 3'd2;
    localparam logic [2:0] S_MUL_C = 3'd3;
    localparam logic [2:0] S_SUB   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [IW-1:0] IDX_LAST = IW'(size - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    localparam logic [data_size-1:0] SAT_MAX = {1'b0, {(data_size-1){1'b1}}};
    localparam logic [data_size-1:0] SAT_MIN = {1'b1, {(data_size-1){1'b0}}};

    logic [2:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [data_size-1:0] r_p;
    logic [VW-1:0]        r_w;
    logic [VW-1:0]        r_dc;
    logic [VW-1:0]        r_dta;
    logic [VW-1:0]        r_ds;
    logic [data_size-1:0] r_lr;
    logic                 r_out_valid;
    logic [VW-1:0]        r_weight_out;

    logic [data_size-1:0]        w_dc_e;
    logic [data_size-1:0]        w_dta_e;
    logic [data_size-1:0]        w_ds_e;
    logic [data_size-1:0]        w_w_e;
    logic signed [data_size-1:0] w_op_a;
    logic signed [data_size-1:0] w_op_b;
    logic signed [PW-1:0]        w_prod;
    logic signed [PW-1:0]        w_shift;
    logic [data_size-1:0]        w_mul_sat;
    logic signed [data_size:0]   w_diff;
    logic [data_size-1:0]        w_sub_sat;
    logic [VW-1:0]               w_w_next;

    // Select the current element of every captured vector.
    always_comb begin
        w_dc_e  = '0;
        w_dta_e = '0;
        w_ds_e  = '0;
        w_w_e   = '0;
        for (int i = 0; i < size; i++) begin
            if (r_idx == i[IW-1:0]) begin
                w_dc_e  = r_dc[i*data_size +: data_size];
                w_dta_e = r_dta[i*data_size +: data_size];
                w_ds_e  = r_ds[i*data_size +: data_size];
                w_w_e   = r_w[i*data_size +: data_size];
            end
        end
    end

    // Operand steering for the single shared multiplier.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            S_MUL_A: begin w_op_a = w_dc_e; w_op_b = w_dta_e; end
            S_MUL_B: begin w_op_a = r_p;    w_op_b = w_ds_e;  end
            S_MUL_C: begin w_op_a = r_p;    w_op_b = r_lr;    end
            default: begin w_op_a = '0;     w_op_b = '0;      end
        endcase
    end

    assign w_prod  = w_op_a * w_op_b;
    // Arithmetic shift floors toward -inf, which is the intended rounding.
    assign w_shift = w_prod >>> frac_bits;

    // The shifted product fits in data_size bits only if all bits above the
    // result sign bit are copies of it.
    always_comb begin
        if (&w_shift[PW-1:data_size-1] || ~|w_shift[PW-1:data_size-1])
            w_mul_sat = w_shift[data_size-1:0];
        else if (w_shift[PW-1])
            w_mul_sat = SAT_MIN;
        else
            w_mul_sat = SAT_MAX;
    end

    assign w_diff = $signed({w_w_e[data_size-1], w_w_e}) - $signed({r_p[data_size-1], r_p});

    always_comb begin
        if (w_diff[data_size] == w_diff[data_size-1])
            w_sub_sat = w_diff[data_size-1:0];
        else if (w_diff[data_size])
            w_sub_sat = SAT_MIN;
        else
            w_sub_sat = SAT_MAX;
    end

    // Working vector with the current element replaced; registered into
    // weight_out on the SUB->DONE transition so the last element is included.
    always_comb begin
        w_w_next = r_w;
        for (int i = 0; i < size; i++) begin
            if (r_idx == i[IW-1:0])
                w_w_next[i*data_size +: data_size] = w_sub_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_p          <= '0;
            r_w          <= '0;
            r_dc         <= '0;
            r_dta        <= '0;
            r_ds         <= '0;
            r_lr         <= '0;
            r_out_valid  <= 1'b0;
            r_weight_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_w     <= weight;
                        r_dc    <= diff_cost;
                        r_dta   <= diff_to_all;
                        r_ds    <= diff_start;
                        r_lr    <= learning_rate;
                        r_idx   <= '0;
                        r_state <= S_MUL_A;
                    end
                end
                S_MUL_A: begin
                    r_p     <= w_mul_sat;
                    r_state <= S_MUL_B;
                end
                S_MUL_B: begin
                    r_p     <= w_mul_sat;
                    r_state <= S_MUL_C;
                end
                S_MUL_C: begin
                    r_p     <= w_mul_sat;
                    r_state <= S_SUB;
                end
                S_SUB: begin
                    r_w <= w_w_next;
                    if (r_idx == IDX_LAST) begin
                        r_weight_out <= w_w_next;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_ONE;
                        r_state <= S_MUL_A;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign weight_out = r_weight_out;

endmodule
